// File: rtl/serial_addsub_if.sv
// Request/result bundle for the digit-serial add/sub unit.
// master drives operands and start; slave returns handshake status, result and flags.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, r, carry, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, r, carry, overflow, zero
    );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement add/sub, DIGIT bits per clock through a held carry.
// Latency: done pulses WIDTH/DIGIT cycles after the accepting edge.
// Backpressure: start is ignored while busy; it is accepted in IDLE or DONE.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_nxt;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] r_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s;
    logic             accept;
    logic             last;

    assign accept = bus.start && (state != RUN);
    assign last   = (cnt_q == CW'(N - 1));

    // Ripple chain over the low digit of the shifting operand registers.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_q;
        for (int j = 0; j < DIGIT; j++) begin
            s[j]     = a_q[j] ^ b_q[j] ^ c[j];
            c[j + 1] = (a_q[j] & b_q[j]) | (a_q[j] & c[j]) | (b_q[j] & c[j]);
        end
        acc_nxt = (acc_q >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift right each step so the active digit always sits at bit 0;
    // finished digits enter acc from the top, so after N steps acc is aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.sub ? ~bus.b : bus.b;
            c_q   <= bus.sub;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state == RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            c_q   <= c[DIGIT];
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                r_q     <= acc_nxt;
                carry_q <= c[DIGIT];
                ovf_q   <= c[DIGIT] ^ c[DIGIT - 1];
                zero_q  <= (acc_nxt == '0);
            end
        end
    end

    assign bus.ready    = (state != RUN);
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.r        = r_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;

    a_done_pulse: assert property (@(posedge clk) disable iff (rst) bus.done |=> !bus.done);
    a_ready_busy: assert property (@(posedge clk) disable iff (rst) bus.ready == !bus.busy);
endmodule

// File: tb/tb_serial_addsub.sv
// Random and directed checks of serial_addsub against an arithmetic reference model.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) b8 ();
    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    logic        s16_start = 1'b0;
    logic        s16_sub   = 1'b0;
    logic [15:0] s16_a     = '0;
    logic [15:0] s16_b     = '0;
    logic [15:0] r16 [4];
    logic        c16 [4];
    logic        v16 [4];
    logic        z16 [4];
    logic        d16 [4];

    for (genvar g = 0; g < 4; g++) begin : g16
        serial_addsub_if #(.WIDTH(16)) bus ();
        serial_addsub #(.WIDTH(16), .DIGIT(1 << g)) dut (.clk(clk), .rst(rst), .bus(bus));
        assign bus.start = s16_start;
        assign bus.sub   = s16_sub;
        assign bus.a     = s16_a;
        assign bus.b     = s16_b;
        assign r16[g]    = bus.r;
        assign c16[g]    = bus.carry;
        assign v16[g]    = bus.overflow;
        assign z16[g]    = bus.zero;
        assign d16[g]    = bus.done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signed/unsigned arithmetic on plain integers, reduced modulo 2^w.
    function automatic void model(input int w, input logic s, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] r,
                                  output logic c, output logic v, output logic z);
        longint full, half, av, bv, sa, sb, res, sres;
        full = longint'(1) << w;
        half = full / 2;
        av   = longint'(a) & (full - 1);
        bv   = longint'(b) & (full - 1);
        sa   = (av >= half) ? av - full : av;
        sb   = (bv >= half) ? bv - full : bv;
        if (s) begin
            res  = av - bv;
            sres = sa - sb;
            c    = (av >= bv);
        end else begin
            res  = av + bv;
            sres = sa + sb;
            c    = (res >= full);
        end
        v = (sres < -half) || (sres >= half);
        if (res < 0) res = res + full;
        if (res >= full) res = res - full;
        r = 16'(res);
        z = (res == 0);
    endfunction

    task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b);
        b8.sub   = s;
        b8.a     = a;
        b8.b     = b;
        b8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0;
    endtask

    task automatic wait8(input int lat0, output int lat);
        lat = lat0;
        while (!b8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("w8_done_seen", 32'(b8.done), 32'(1));
    endtask

    task automatic check8(input string tag, input logic s, input logic [7:0] a,
                          input logic [7:0] b, input int lat);
        logic [15:0] er;
        logic        ec, ev, ez;
        model(8, s, {8'h00, a}, {8'h00, b}, er, ec, ev, ez);
        check({tag, "_lat"},  32'(lat),         32'(8));
        check({tag, "_r"},    32'(b8.r),        32'(er[7:0]));
        check({tag, "_c"},    32'(b8.carry),    32'(ec));
        check({tag, "_v"},    32'(b8.overflow), 32'(ev));
        check({tag, "_z"},    32'(b8.zero),     32'(ez));
    endtask

    task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b);
        int lat;
        start8(s, a, b);
        wait8(0, lat);
        check8(tag, s, a, b, lat);
    endtask

    task automatic run16(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] er;
        logic        ec, ev, ez;
        logic        got [4];
        model(16, s, a, b, er, ec, ev, ez);
        for (int g = 0; g < 4; g++) got[g] = 1'b0;
        s16_sub   = s;
        s16_a     = a;
        s16_b     = b;
        s16_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s16_start = 1'b0;
        s16_a     = 16'(~a);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (d16[g] && !got[g]) begin
                    got[g] = 1'b1;
                    check($sformatf("%s_d%0d_lat", tag, 1 << g), 32'(cyc), 32'(16 >> g));
                    check($sformatf("%s_d%0d_r", tag, 1 << g), 32'(r16[g]), 32'(er));
                    check($sformatf("%s_d%0d_c", tag, 1 << g), 32'(c16[g]), 32'(ec));
                    check($sformatf("%s_d%0d_v", tag, 1 << g), 32'(v16[g]), 32'(ev));
                    check($sformatf("%s_d%0d_z", tag, 1 << g), 32'(z16[g]), 32'(ez));
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("%s_d%0d_seen", tag, 1 << g), 32'(got[g]), 32'(1));
            check($sformatf("%s_d%0d_hold", tag, 1 << g), 32'(r16[g]), 32'(er));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   seen;
        logic s;
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;

        b8.start = 1'b0;
        b8.sub   = 1'b0;
        b8.a     = '0;
        b8.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_r",     32'(b8.r),        32'(0));
        check("rst_c",     32'(b8.carry),    32'(0));
        check("rst_v",     32'(b8.overflow), 32'(0));
        check("rst_z",     32'(b8.zero),     32'(0));
        check("rst_done",  32'(b8.done),     32'(0));
        check("rst_busy",  32'(b8.busy),     32'(0));
        check("rst_ready", 32'(b8.ready),    32'(1));
        rst = 1'b0;
        @(negedge clk);

        run8("sub_5_3", 1'b1, 8'h05, 8'h03);
        check("sub_5_3_lit", 32'(b8.r), 32'(8'h02));

        // New request in the DONE cycle: accepted, old result held until next done.
        start8(1'b1, 8'h03, 8'h05);
        check("b2b_done_drop", 32'(b8.done), 32'(0));
        check("b2b_busy",      32'(b8.busy), 32'(1));
        check("b2b_r_held",    32'(b8.r),    32'(8'h02));
        wait8(0, lat);
        check8("sub_3_5", 1'b1, 8'h03, 8'h05, lat);
        check("sub_3_5_lit", 32'(b8.r), 32'(8'hFE));

        run8("sub_80_1", 1'b1, 8'h80, 8'h01);
        check("sub_80_1_ovf", 32'(b8.overflow), 32'(1));
        run8("add_7f_1", 1'b0, 8'h7F, 8'h01);
        check("add_7f_1_lit", 32'(b8.r), 32'(8'h80));
        run8("add_ff_1", 1'b0, 8'hFF, 8'h01);
        check("add_ff_1_zero", 32'(b8.zero), 32'(1));
        @(negedge clk);
        check("done_one_cycle", 32'(b8.done), 32'(0));

        // Start and operand changes while busy must not disturb the op in flight.
        start8(1'b0, 8'h10, 8'h20);
        lat = 0;
        repeat (2) begin @(negedge clk); lat++; end
        b8.start = 1'b1;
        b8.sub   = 1'b1;
        b8.a     = 8'hAA;
        b8.b     = 8'h55;
        @(negedge clk);
        lat++;
        b8.start = 1'b0;
        wait8(lat, lat);
        check8("busy_ignore", 1'b0, 8'h10, 8'h20, lat);
        @(negedge clk);
        check("busy_ignore_idle", 32'(b8.busy), 32'(0));

        start8(1'b0, 8'h33, 8'h44);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_r",     32'(b8.r),        32'(0));
        check("mid_rst_c",     32'(b8.carry),    32'(0));
        check("mid_rst_v",     32'(b8.overflow), 32'(0));
        check("mid_rst_z",     32'(b8.zero),     32'(0));
        check("mid_rst_busy",  32'(b8.busy),     32'(0));
        check("mid_rst_ready", 32'(b8.ready),    32'(1));
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (b8.done) seen++;
        end
        check("mid_rst_no_done", 32'(seen), 32'(0));
        run8("after_rst", 1'b0, 8'h33, 8'h44);

        for (int i = 0; i < 10; i++) begin
            s  = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8($sformatf("rnd8_%0d", i), s, ra, rb);
        end

        run16("w16_1234", 1'b1, 16'h1234, 16'h0235);
        check("w16_1234_lit", 32'(r16[2]), 32'(16'h0FFF));
        run16("w16_ffff_1", 1'b0, 16'hFFFF, 16'h0001);
        run16("w16_8000_1", 1'b1, 16'h8000, 16'h0001);
        run16("w16_0_0",    1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < 25; i++) begin
            s  = 1'($urandom_range(0, 1));
            wa = 16'($urandom);
            wb = 16'($urandom);
            run16($sformatf("rnd16_%0d", i), s, wa, wb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
